gmii_tx_mac: RTL and testbench

//  Transmit-side MAC framer feeding the GMII TX inputs of the RGMII converter, on gmii_tx_clk.

---
 rtl/gmii_tx_mac.sv | 128 ++++++++++++
 tb/tb_gmii_tx_mac.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_mac.sv
// gmii_tx_mac: frames a valid/ready/last byte stream into GMII TX (preamble, SFD, payload, zero pad, CRC-32 FCS, IFG), flags upstream underrun on gmii_tx_er, pulses tx_done/tx_underrun
module gmii_tx_mac #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_done,
  output logic       tx_underrun
);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP} state_t;
  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d, er_q, er_d, done_q, done_d, urun_q, urun_d;
  logic        short_frame;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign s_ready     = state_q == DATA || state_q == DROP;
  assign short_frame = cnt_q < 11'(MIN_PAYLOAD - 1);
  assign gmii_txd    = txd_q;
  assign gmii_tx_en  = en_q;
  assign gmii_tx_er  = er_q;
  assign tx_done     = done_q;
  assign tx_underrun = urun_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    txd_d   = 8'h00;
    en_d    = 1'b0;
    er_d    = 1'b0;
    done_d  = 1'b0;
    urun_d  = 1'b0;
    case (state_q)
      IDLE: if (s_valid) begin
        txd_d   = 8'h55;
        en_d    = 1'b1;
        cnt_d   = 11'd1;
        state_d = (PREAMBLE_LEN > 1) ? PRE : SFD;
      end
      PRE: begin
        txd_d   = 8'h55;
        en_d    = 1'b1;
        cnt_d   = cnt_q + 11'd1;
        state_d = (cnt_q == 11'(PREAMBLE_LEN - 1)) ? SFD : PRE;
      end
      SFD: begin
        txd_d   = 8'hD5;
        en_d    = 1'b1;
        cnt_d   = '0;
        crc_d   = '1;
        state_d = DATA;
      end
      DATA: begin
        en_d = 1'b1;
        if (s_valid) begin
          txd_d = s_data;
          crc_d = crc_byte(crc_q, s_data);
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 11'd1;
          if (s_last) begin
            state_d = short_frame ? PAD : FCS;
            cnt_d   = short_frame ? cnt_q + 11'd1 : '0;
          end
        end else begin
          er_d    = 1'b1;
          urun_d  = 1'b1;
          state_d = DROP;
        end
      end
      PAD: begin
        en_d    = 1'b1;
        crc_d   = crc_byte(crc_q, 8'h00);
        state_d = (cnt_q == 11'(MIN_PAYLOAD - 1)) ? FCS : PAD;
        cnt_d   = (cnt_q == 11'(MIN_PAYLOAD - 1)) ? '0 : cnt_q + 11'd1;
      end
      FCS: begin
        en_d    = 1'b1;
        txd_d   = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
        done_d  = cnt_q[1:0] == 2'd3;
        state_d = (cnt_q[1:0] == 2'd3) ? IFG : FCS;
        cnt_d   = (cnt_q[1:0] == 2'd3) ? '0 : cnt_q + 11'd1;
      end
      IFG: begin
        state_d = (cnt_q == 11'(IFG_CYCLES - 1)) ? IDLE : IFG;
        cnt_d   = (cnt_q == 11'(IFG_CYCLES - 1)) ? '0 : cnt_q + 11'd1;
      end
      DROP: if (s_valid && s_last) begin
        state_d = IFG;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= '1;
      txd_q   <= '0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      er_q    <= er_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
endmodule

// File: tb/tb_gmii_tx_mac.sv
// tb_gmii_tx_mac: randomized frame streams checked against a frame-level model of the GMII transmit framer
module tb_gmii_tx_mac;
  localparam int PRE_N = 7;
  localparam int MIN_N = 60;
  localparam int IFG_N = 12;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, tx_done, tx_underrun;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] pay[$];
  int         flen[$];
  int         fur[$];
  logic [7:0] txd_l[$];
  logic       en_l[$], er_l[$], dn_l[$], ur_l[$], rd_l[$];
  always #5 clk = ~clk;
  gmii_tx_mac dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .tx_done(tx_done), .tx_underrun(tx_underrun)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] crc_raw(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[k])
      for (int i = 0; i < 8; i++) c = (c[0] ^ b[k][i]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction
  function automatic void clear_frames();
    pay.delete();
    flen.delete();
    fur.delete();
  endfunction
  function automatic void add_frame(input int len, input int ur, input bit ramp);
    for (int i = 0; i < len; i++) pay.push_back(ramp ? 8'(i) : 8'($urandom));
    flen.push_back(len);
    fur.push_back(ur);
  endfunction
  task automatic run_stream(input bit tog, input int rst_at);
    int fi, bi, base, tail, acc;
    bit urd;
    fi = 0; bi = 0; base = 0; tail = 0; acc = 0; urd = 0;
    txd_l.delete(); en_l.delete(); er_l.delete(); dn_l.delete(); ur_l.delete(); rd_l.delete();
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      txd_l.push_back(gmii_txd);
      en_l.push_back(gmii_tx_en);
      er_l.push_back(gmii_tx_er);
      dn_l.push_back(tx_done);
      ur_l.push_back(tx_underrun);
      rd_l.push_back(s_ready);
      if (fi < flen.size()) begin
        s_data = pay[base+bi];
        s_last = bi == flen[fi] - 1;
        if (s_ready) s_valid = !(fur[fi] == bi && !urd);
        else s_valid = tog ? 1'($urandom_range(0, 1)) : 1'b1;
        if (s_ready && !s_valid) urd = 1;
        if (s_ready && s_valid) begin
          bi++;
          acc++;
          if (bi == flen[fi]) begin
            base += flen[fi];
            fi++;
            bi = 0;
            urd = 0;
          end
        end
        if (rst_at >= 0 && acc == rst_at) begin
          #2 rst_n = 1'b0;
          #1;
          check("async reset txd", gmii_txd, 0);
          check("async reset tx_en", gmii_tx_en, 0);
          check("async reset tx_er", gmii_tx_er, 0);
          check("async reset s_ready", s_ready, 0);
          s_valid = 1'b0;
          s_last = 1'b0;
          return;
        end
      end else begin
        s_valid = 1'b0;
        s_last = 1'b0;
        if (++tail > 100) break;
      end
    end
    check("frames accepted", fi, flen.size());
  endtask
  task automatic analyze(input bit held);
    int nb, prev_end, base, c, s, e, len, ur, m, mi, bad, stray, gap;
    bit prev_good, rdy;
    logic [7:0] ex[$];
    logic [7:0] pd[$];
    logic [7:0] rx[$];
    logic [31:0] fcs;
    nb = 0; prev_end = -1; base = 0; c = 0; stray = 0; prev_good = 0;
    while (c < en_l.size()) begin
      if (!en_l[c]) begin
        if (er_l[c] || dn_l[c] || ur_l[c] || txd_l[c] != 8'h00) stray++;
        c++;
        continue;
      end
      s = c;
      while (c < en_l.size() && en_l[c]) c++;
      e = c - 1;
      len = c - s;
      if (nb < flen.size()) begin
        ur = fur[nb];
        ex.delete();
        pd.delete();
        for (int i = 0; i < (ur >= 0 ? ur : flen[nb]); i++) pd.push_back(pay[base+i]);
        if (ur < 0) while (pd.size() < MIN_N) pd.push_back(8'h00);
        repeat (PRE_N) ex.push_back(8'h55);
        ex.push_back(8'hD5);
        foreach (pd[k]) ex.push_back(pd[k]);
        if (ur >= 0) ex.push_back(8'h00);
        else begin
          fcs = ~crc_raw(pd);
          for (int j = 0; j < 4; j++) ex.push_back(fcs[8*j +: 8]);
        end
        check($sformatf("f%0d length", nb), len, ex.size());
        m = len < ex.size() ? len : ex.size();
        mi = m - 1;
        for (int k = 0; k < m; k++)
          if (txd_l[s+k] !== ex[k]) begin
            mi = k;
            break;
          end
        check($sformatf("f%0d byte%0d", nb, mi), txd_l[s+mi], ex[mi]);
        bad = 0;
        for (int k = 0; k < len; k++) begin
          if (er_l[s+k] !== (ur >= 0 && k == len - 1)) bad++;
          if (ur_l[s+k] !== (ur >= 0 && k == len - 1)) bad++;
          if (dn_l[s+k] !== (ur < 0 && k == len - 1)) bad++;
        end
        check($sformatf("f%0d er/done/underrun placement errors", nb), bad, 0);
        rdy = 0;
        for (int k = 0; k < PRE_N && k < len; k++) rdy |= rd_l[s+k];
        check($sformatf("f%0d s_ready during preamble", nb), rdy, 0);
        if (len > PRE_N) check($sformatf("f%0d s_ready at SFD", nb), rd_l[s+PRE_N], 1);
        if (ur < 0 && len > PRE_N + 1) begin
          rx.delete();
          for (int k = s + PRE_N + 1; k <= e; k++) rx.push_back(txd_l[k]);
          check($sformatf("f%0d crc residue", nb), crc_raw(rx), 32'hDEBB20E3);
          rdy = 0;
          for (int k = e; k <= e + IFG_N && k < rd_l.size(); k++) rdy |= rd_l[k];
          check($sformatf("f%0d s_ready during IFG", nb), rdy, 0);
        end
        if (nb == 0 && held) check("start latency", s, 1);
        if (nb > 0) begin
          gap = s - prev_end - 1;
          if (held && prev_good) check($sformatf("f%0d gap", nb), gap, IFG_N);
          else check($sformatf("f%0d gap >= IFG (gap %0d)", nb, gap), gap >= IFG_N, 1);
        end
        base += flen[nb];
        prev_good = ur < 0;
      end
      prev_end = e;
      nb++;
    end
    check("burst count", nb, flen.size());
    check("activity while tx_en low", stray, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset txd", gmii_txd, 0);
    check("reset tx_en", gmii_tx_en, 0);
    check("reset tx_er", gmii_tx_er, 0);
    check("reset tx_done", tx_done, 0);
    check("reset tx_underrun", tx_underrun, 0);
    check("reset s_ready", s_ready, 0);
    rst_n = 1'b1;
    clear_frames();
    pay.push_back(8'hAB);
    flen.push_back(1);
    fur.push_back(-1);
    run_stream(0, -1);
    analyze(1);
    clear_frames();
    add_frame(64, -1, 1);
    add_frame(64, -1, 1);
    run_stream(0, -1);
    analyze(1);
    clear_frames();
    add_frame(30, 10, 0);
    add_frame(20, -1, 0);
    run_stream(0, -1);
    analyze(1);
    clear_frames();
    add_frame(59, -1, 0);
    add_frame(60, -1, 0);
    add_frame(61, -1, 0);
    add_frame(5, 4, 0);
    add_frame(8, -1, 0);
    run_stream(0, -1);
    analyze(1);
    for (int r = 0; r < 6; r++) begin
      int nf, len;
      clear_frames();
      nf = $urandom_range(2, 4);
      for (int f = 0; f < nf; f++) begin
        len = $urandom_range(1, 100);
        add_frame(len, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1, 0);
      end
      run_stream(1, -1);
      analyze(0);
    end
    clear_frames();
    add_frame(40, -1, 0);
    run_stream(0, 20);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_frames();
    add_frame(50, -1, 0);
    run_stream(0, -1);
    analyze(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
